// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ALU control codes, MDU op codes and MDU state encoding
// for the execute stage.  Revision 1.0
`default_nettype none

package pipe_pkg;

    localparam int RA_REG = 31;

    // Add/sub/logic/lui codes ignore bit 3; only bits [2:0] are decoded for them.
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [2:0] MDU_OP_NONE  = 3'd0;
    localparam logic [2:0] MDU_OP_MULT  = 3'd1;
    localparam logic [2:0] MDU_OP_MULTU = 3'd2;
    localparam logic [2:0] MDU_OP_DIV   = 3'd3;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
    localparam logic [2:0] MDU_OP_MFHI  = 3'd5;
    localparam logic [2:0] MDU_OP_MFLO  = 3'd6;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_mdu_start(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_exe_stage_if.sv
// pipe_exe_stage_if: ID/EX-to-EX/MEM signal bundle of the execute stage.
// Revision 1.0
`default_nettype none

interface pipe_exe_stage_if;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] eimm;
    logic [31:0] epc4;
    logic [4:0]  ern;
    logic [3:0]  ealuc;
    logic        ealuimm;
    logic        eshift;
    logic        ejal;
    logic [2:0]  emdu_op;
    logic [31:0] ealu;
    logic [4:0]  ern0;
    logic        mdu_stall;
    logic [31:0] ehi;
    logic [31:0] elo;

    modport master (
        output ea, eb, eimm, epc4, ern, ealuc, ealuimm, eshift, ejal, emdu_op,
        input  ealu, ern0, mdu_stall, ehi, elo
    );

    modport slave (
        input  ea, eb, eimm, epc4, ern, ealuc, ealuimm, eshift, ejal, emdu_op,
        output ealu, ern0, mdu_stall, ehi, elo
    );
endinterface

`default_nettype wire

// File: rtl/pipe_mdu.sv
// pipe_mdu: iterative 32-step multiply/divide unit holding HI/LO.
// Revision 1.0
`default_nettype none

module pipe_mdu
    import pipe_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        clrn,
    input  wire logic [2:0]  i_op,
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    output logic             o_stall,
    output logic [31:0]      o_hi,
    output logic [31:0]      o_lo
);

    mdu_state_t  r_state;
    mdu_state_t  w_state_nxt;
    logic [4:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_b;
    logic        r_is_div;
    logic        r_neg_lo;
    logic        r_neg_hi;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_start;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_sum;
    logic [32:0] w_trial;
    logic [63:0] w_step;
    logic [63:0] w_prod;
    logic [31:0] w_fin_hi;
    logic [31:0] w_fin_lo;

    assign w_start  = (r_state == MDU_IDLE) && is_mdu_start(i_op);
    assign w_signed = (i_op == MDU_OP_MULT) || (i_op == MDU_OP_DIV);
    assign w_a_neg  = w_signed & i_a[31];
    assign w_b_neg  = w_signed & i_b[31];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign w_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_trial = {r_acc[63:32], r_acc[31]} - {1'b0, r_b};
    assign w_step  = r_is_div ?
                     (w_trial[32] ? {r_acc[62:0], 1'b0} : {w_trial[31:0], r_acc[30:0], 1'b1}) :
                     {w_sum, r_acc[31:1]};

    assign w_prod   = r_neg_lo ? -w_step : w_step;
    assign w_fin_lo = r_is_div ? (r_neg_lo ? -w_step[31:0] : w_step[31:0]) : w_prod[31:0];
    assign w_fin_hi = r_is_div ? (r_neg_hi ? -w_step[63:32] : w_step[63:32]) : w_prod[63:32];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_stall     = 1'b0;
        case (r_state)
            MDU_IDLE: begin
                if (w_start) begin
                    w_state_nxt = MDU_BUSY;
                    o_stall     = 1'b1;
                end
            end
            MDU_BUSY: begin
                o_stall = 1'b1;
                if (r_count == 5'd31) begin
                    w_state_nxt = MDU_DONE;
                end
            end
            MDU_DONE: begin
                w_state_nxt = MDU_IDLE;
            end
            default: begin
                w_state_nxt = MDU_IDLE;
            end
        endcase
        o_stall = o_stall & clrn;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_count  <= 5'd0;
            r_acc    <= 64'd0;
            r_b      <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else if (w_start) begin
            r_count  <= 5'd0;
            r_acc    <= {32'd0, w_a_mag};
            r_b      <= w_b_mag;
            r_is_div <= (i_op == MDU_OP_DIV) || (i_op == MDU_OP_DIVU);
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_a_neg;
        end else if (r_state == MDU_BUSY) begin
            r_acc   <= w_step;
            r_count <= r_count + 5'd1;
            if (r_count == 5'd31) begin
                r_hi <= w_fin_hi;
                r_lo <= w_fin_lo;
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

`default_nettype wire

// File: rtl/pipe_exe_stage.sv
// pipe_exe_stage: MIPS execute stage (ALU, jal link, result mux, optional MDU).
// The MDU with HI/LO is built only when PIPE_EXE_MDU_EN is defined.  Revision 1.0
`default_nettype none

module pipe_exe_stage
    import pipe_pkg::*;
#(
    parameter int DW     = 32,
    parameter int RA_REG = pipe_pkg::RA_REG
) (
    input  wire logic         clk,
    input  wire logic         clrn,
    pipe_exe_stage_if.slave   bus
);

    logic [DW-1:0] w_alu_a;
    logic [DW-1:0] w_alu_b;
    logic [DW-1:0] w_alu_y;
    logic [4:0]    w_sh;
    logic [DW-1:0] w_hi;
    logic [DW-1:0] w_lo;
    logic          w_stall;

    assign w_alu_a = bus.eshift  ? {27'd0, bus.eimm[10:6]} : bus.ea;
    assign w_alu_b = bus.ealuimm ? bus.eimm : bus.eb;
    assign w_sh    = w_alu_a[4:0];

    always_comb begin
        w_alu_y = '0;
        case (bus.ealuc[2:0])
            ALUC_ADD[2:0]: w_alu_y = w_alu_a + w_alu_b;
            ALUC_SUB[2:0]: w_alu_y = w_alu_a - w_alu_b;
            ALUC_AND[2:0]: w_alu_y = w_alu_a & w_alu_b;
            ALUC_OR[2:0]:  w_alu_y = w_alu_a | w_alu_b;
            ALUC_XOR[2:0]: w_alu_y = w_alu_a ^ w_alu_b;
            ALUC_LUI[2:0]: w_alu_y = w_alu_b << 16;
            ALUC_SLL[2:0]: w_alu_y = (bus.ealuc == ALUC_SLL) ? (w_alu_b << w_sh) : '0;
            ALUC_SRL[2:0]: w_alu_y = (bus.ealuc == ALUC_SRA) ?
                                     DW'($signed(w_alu_b) >>> w_sh) : (w_alu_b >> w_sh);
        endcase
    end

`ifdef PIPE_EXE_MDU_EN
    pipe_mdu u_mdu (
        .clk     (clk),
        .clrn    (clrn),
        .i_op    (bus.emdu_op),
        .i_a     (bus.ea),
        .i_b     (bus.eb),
        .o_stall (w_stall),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );
`else
    logic w_unused_clk;
    assign w_unused_clk = ^{clk, clrn};
    assign w_stall      = 1'b0;
    assign w_hi         = '0;
    assign w_lo         = '0;
`endif

    always_comb begin
        bus.ern0 = bus.ejal ? 5'(RA_REG) : bus.ern;
        if (bus.ejal) begin
            bus.ealu = bus.epc4 + 32'd4;
        end else if (bus.emdu_op == MDU_OP_MFHI) begin
            bus.ealu = w_hi;
        end else if (bus.emdu_op == MDU_OP_MFLO) begin
            bus.ealu = w_lo;
        end else begin
            bus.ealu = w_alu_y;
        end
    end

    assign bus.mdu_stall = w_stall;
    assign bus.ehi       = w_hi;
    assign bus.elo       = w_lo;

endmodule

`default_nettype wire

// File: tb/tb_pipe_exe_stage.sv
// tb_pipe_exe_stage: randomized self-checking bench for pipe_exe_stage with
// a behavioural ALU/MDU reference model.  Revision 1.0
`default_nettype none

module tb_pipe_exe_stage;

    logic clk;
    logic clrn;
    int   tests;
    int   fails;

    pipe_exe_stage_if bus();

    pipe_exe_stage u_dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(a % 32);
        if (c == 4'b0011) return b << sh;
        if (c == 4'b0111) return b >> sh;
        if (c == 4'b1111) return 32'($signed(b) >>> sh);
        case (c % 8)
            0: return a + b;
            4: return a - b;
            1: return a & b;
            5: return a | b;
            2: return a ^ b;
            6: return {b[15:0], 16'd0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void mdu_ref(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] hi,
                                    output logic [31:0] lo);
        longint      p;
        logic [63:0] u;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {hi, lo} = p; end
            3'd2: begin u = {32'd0, a} * {32'd0, b}; {hi, lo} = u; end
            3'd3: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = a[31] ? 32'd1 : 32'hFFFFFFFF;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    hi = 32'd0;
                    lo = 32'h80000000;
                end else begin
                    lo = $signed(a) / $signed(b);
                    hi = $signed(a) % $signed(b);
                end
            end
            3'd4: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFFFFFF;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic drive_idle();
        bus.ea = 32'd0; bus.eb = 32'd0; bus.eimm = 32'd0; bus.epc4 = 32'd0;
        bus.ern = 5'd0; bus.ealuc = 4'd0; bus.ealuimm = 1'b0; bus.eshift = 1'b0;
        bus.ejal = 1'b0; bus.emdu_op = 3'd0;
    endtask

    task automatic test_reset();
        drive_idle();
        clrn = 1'b0;
        bus.emdu_op = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.mdu_stall !== 1'b0) begin
            fails++; $display("FAIL reset_stall: got %b, expected 0", bus.mdu_stall);
        end
        tests++;
        if (bus.ehi !== 32'd0 || bus.elo !== 32'd0) begin
            fails++; $display("FAIL reset_hilo: got %h_%h, expected 0_0", bus.ehi, bus.elo);
        end
        bus.emdu_op = 3'd0;
        @(posedge clk); #1;
        clrn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_directed();
        logic [31:0] res [4];
        logic [31:0] exp [4];
        bus.ealuc = 4'b0000; bus.ea = 32'd5; bus.eb = 32'hFFFFFFFF; #1; res[0] = bus.ealu;
        exp[0] = 32'd4;
        bus.ealuc = 4'b0100; bus.ea = 32'd0; bus.eb = 32'd1; #1; res[1] = bus.ealu;
        exp[1] = 32'hFFFFFFFF;
        bus.eshift = 1'b1; bus.eimm = 32'd4 << 6; bus.ealuc = 4'b1111; bus.eb = 32'h80000000;
        #1; res[2] = bus.ealu; exp[2] = 32'hF8000000;
        bus.ealuc = 4'b0110; bus.eshift = 1'b0; bus.ealuimm = 1'b1; bus.eimm = 32'h00001234;
        #1; res[3] = bus.ealu; exp[3] = 32'h12340000;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (res[i] !== exp[i]) begin
                fails++; $display("FAIL alu_directed[%0d]: got %h, expected %h", i, res[i], exp[i]);
            end
        end
        drive_idle();
    endtask

    task automatic test_jal();
        bus.ejal = 1'b1; bus.epc4 = 32'h100; bus.ern = 5'd0; bus.ea = 32'h55; #1;
        tests++;
        if (bus.ealu !== 32'h104 || bus.ern0 !== 5'd31) begin
            fails++; $display("FAIL jal: got %h/%0d, expected 00000104/31", bus.ealu, bus.ern0);
        end
        bus.ejal = 1'b0; bus.ern = 5'd9; #1;
        tests++;
        if (bus.ern0 !== 5'd9) begin
            fails++; $display("FAIL ern_pass: got %0d, expected 9", bus.ern0);
        end
        drive_idle();
    endtask

    task automatic test_alu_random();
        logic [3:0]  codes [9];
        logic [31:0] a, b, e;
        int          bad;
        codes = '{4'b0000, 4'b1100, 4'b0001, 4'b1101, 4'b0010, 4'b1110, 4'b0011, 4'b0111, 4'b1111};
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            bus.ea = $urandom; bus.eb = $urandom; bus.eimm = $urandom;
            bus.eshift = 1'($urandom_range(0, 1)); bus.ealuimm = 1'($urandom_range(0, 1));
            bus.ealuc = codes[$urandom_range(0, 8)];
            bus.ern = 5'($urandom);
            a = bus.eshift ? {27'd0, bus.eimm[10:6]} : bus.ea;
            b = bus.ealuimm ? bus.eimm : bus.eb;
            e = alu_ref(bus.ealuc, a, b);
            #1;
            tests++;
            if (bus.ealu !== e || bus.ern0 !== bus.ern) begin
                fails++; bad++;
                if (bad < 5)
                    $display("FAIL alu_random: aluc=%b got %h, expected %h", bus.ealuc, bus.ealu, e);
            end
        end
        drive_idle();
    endtask

`ifdef PIPE_EXE_MDU_EN
    task automatic run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string nm);
        logic [31:0] eh, el;
        logic        bad;
        mdu_ref(op, a, b, eh, el);
        @(posedge clk); #1;
        bus.emdu_op = op; bus.ea = a; bus.eb = b; #1;
        tests++;
        if (bus.mdu_stall !== 1'b1) begin
            fails++; $display("FAIL %s_stall_T: got %b, expected 1", nm, bus.mdu_stall);
        end
        bad = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            if (bus.mdu_stall !== 1'b1) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++; $display("FAIL %s_stall_busy: got a low cycle, expected 1 for T+1..T+32", nm);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.mdu_stall !== 1'b0) begin
            fails++; $display("FAIL %s_stall_done: got %b, expected 0", nm, bus.mdu_stall);
        end
        tests++;
        if (bus.ehi !== eh || bus.elo !== el) begin
            fails++;
            $display("FAIL %s_hilo: a=%h b=%h got %h_%h, expected %h_%h", nm, a, b,
                     bus.ehi, bus.elo, eh, el);
        end
        @(posedge clk); #1;
        bus.emdu_op = 3'd0;
    endtask

    task automatic test_mult_mflo();
        run_mdu(3'd1, 32'hFFFFFFFE, 32'd3, "mult");
        bus.emdu_op = 3'd6; #1;
        tests++;
        if (bus.ealu !== 32'hFFFFFFFA) begin
            fails++; $display("FAIL mflo_1: got %h, expected fffffffa", bus.ealu);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.ealu !== 32'hFFFFFFFA || bus.mdu_stall !== 1'b0) begin
            fails++; $display("FAIL mflo_2: got %h/%b, expected fffffffa/0", bus.ealu, bus.mdu_stall);
        end
        bus.emdu_op = 3'd5; #1;
        tests++;
        if (bus.ealu !== 32'hFFFFFFFF) begin
            fails++; $display("FAIL mfhi: got %h, expected ffffffff", bus.ealu);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.mdu_stall !== 1'b0 || bus.elo !== 32'hFFFFFFFA) begin
            fails++; $display("FAIL no_restart: got %b/%h, expected 0/fffffffa", bus.mdu_stall, bus.elo);
        end
        drive_idle();
    endtask

    task automatic test_div();
        run_mdu(3'd3, 32'hFFFFFFF9, 32'd2, "div_neg");
        run_mdu(3'd4, 32'd9, 32'd0, "divu_zero");
        run_mdu(3'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_mdu(3'd3, 32'hFFFFFFF9, 32'd0, "div_zero_neg");
    endtask

    task automatic test_abort();
        @(posedge clk); #1;
        bus.emdu_op = 3'd1; bus.ea = 32'd1234; bus.eb = 32'd5678;
        repeat (10) @(posedge clk);
        #1;
        clrn = 1'b0; #1;
        tests++;
        if (bus.mdu_stall !== 1'b0 || bus.ehi !== 32'd0 || bus.elo !== 32'd0) begin
            fails++;
            $display("FAIL abort: got stall=%b hi=%h lo=%h, expected 0/0/0", bus.mdu_stall, bus.ehi, bus.elo);
        end
        @(posedge clk); #1;
        bus.emdu_op = 3'd0;
        @(posedge clk); #1;
        clrn = 1'b1;
        run_mdu(3'd1, 32'd1234, 32'hFFFFD000, "mult_after_abort");
    endtask

    task automatic test_mdu_random();
        logic [31:0] a, b;
        logic [2:0]  op;
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 4 == 1) b = -b;
            run_mdu(op, a, b, "mdu_random");
        end
    endtask
`else
    task automatic test_mdu_disabled();
        logic [31:0] a, b;
        int          bad;
        bad = 0;
        for (int i = 1; i <= 4; i++) begin
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            bus.emdu_op = 3'(i); bus.ea = a; bus.eb = b; bus.ealuc = 4'b0000; #1;
            tests++;
            if (bus.mdu_stall !== 1'b0 || bus.ealu !== a + b) begin
                fails++; $display("FAIL nop_op%0d: got %b/%h, expected 0/%h", i, bus.mdu_stall, bus.ealu, a + b);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (bus.mdu_stall !== 1'b0 || bus.ehi !== 32'd0 || bus.elo !== 32'd0) begin
            fails++; $display("FAIL disabled_hilo: got %b/%h/%h, expected 0/0/0", bus.mdu_stall, bus.ehi, bus.elo);
        end
        for (int i = 5; i <= 6; i++) begin
            bus.emdu_op = 3'(i); #1;
            tests++;
            if (bus.ealu !== 32'd0) begin
                fails++; $display("FAIL disabled_mf%0d: got %h, expected 0", i, bus.ealu);
            end
        end
        drive_idle();
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        clrn  = 1'b0;
        drive_idle();
        test_reset();
        test_alu_directed();
        test_jal();
        test_alu_random();
`ifdef PIPE_EXE_MDU_EN
        test_mult_mflo();
        test_div();
        test_abort();
        test_mdu_random();
`else
        test_mdu_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_exe_stage.md
Name: pipe_exe_stage

Overview:
Execute stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX register.
- Consumes the ID/EX outputs (operands, immediate, ALU control, shift/jal flags, destination register, pc+4).
- Produces the ALU/link result and final destination register number for the EX/MEM register.
- Contains an iterative multiply/divide unit (MDU) with HI/LO registers; stalls the front end while the MDU is busy.

Parameters:
DW, 32, datapath width (only 32 supported)
RA_REG, 31, register written by jal

Ports:
clk  in  1  clock
clrn  in  1  reset
ea  in  32  operand A
eb  in  32  operand B
eimm  in  32  sign/zero-extended immediate; bits [10:6] = shamt
epc4  in  32  pc+4 of this instruction
ern  in  5  decoded destination register
ealuc  in  4  ALU control
ealuimm  in  1  select eimm as B operand
eshift  in  1  select shamt as A operand
ejal  in  1  jal/link instruction
emdu_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 reserved (treated as none)
ealu  out  32  stage result to EX/MEM
ern0  out  5  final destination register
mdu_stall  out  1  hold PC, IF/ID and ID/EX
ehi  out  32  HI register
elo  out  32  LO register

Behaviour:
Reset: clrn is asynchronous, active-low; clock is clk.
- Reset values: FSM IDLE, count 0, HI/LO 0, internal operand/accumulator registers 0.
- ealu, ern0 and mdu_stall are combinational; mdu_stall = 0 while in reset.

ALU (combinational):
- A = eshift ? {27'b0, eimm[10:6]} : ea.
- B = ealuimm ? eimm : eb.
- ealuc x000 add; x100 sub; x001 and; x101 or; x010 xor; x110 lui (B<<16); 0011 sll B by A[4:0]; 0111 srl; 1111 sra.
- Add/sub wrap modulo 2^32; no overflow trap.

Result mux:
- ejal: ealu = epc4 + 4, ern0 = RA_REG.
- Otherwise ern0 = ern.
- emdu_op 5/6: ealu = HI/LO.
- Otherwise ealu = ALU result.

MDU FSM (IDLE, BUSY, DONE):
- IDLE with emdu_op 1-4 in cycle T:
  - mdu_stall = 1 in cycle T.
  - Latch operand magnitudes (signed ops) and result signs.
  - count = 0; state goes to BUSY.
- BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle; mdu_stall = 1.
  - After 32 steps (cycles T+1..T+32), write HI/LO with sign-corrected results and go to DONE.
- DONE (T+33): mdu_stall = 0; the same instruction, still held in ID/EX, retires and does NOT restart; state returns to IDLE.
- Total stall: 33 cycles; HI/LO valid from T+33.
- mult/multu: HI:LO = 64-bit product.
- div/divu: LO = quotient, HI = remainder; remainder takes the sign of the dividend.
- Divide by zero: no trap, result is the natural restoring result — LO = 0xFFFFFFFF (divu), HI = dividend. Signed div: quotient magnitude all ones, then sign-corrected.
- div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- mfhi/mflo cannot reach EX while BUSY (front end stalled); in DONE they read the new HI/LO.
- clrn low mid-operation: aborts immediately; HI/LO = 0, state IDLE, stall released.

Optional Feature:
PIPE_EXE_MDU_EN
- Defined: MDU, HI/LO and FSM present as above.
- Undefined:
  - No MDU logic; mdu_stall tied 0.
  - ehi/elo tied 0.
  - emdu_op 1-4 behave as nop (ealu = ALU result); mfhi/mflo return 0.

Decomposition:
- Shared package (pipe_pkg): ALUC_* 4-bit codes, MDU_OP_* 3-bit codes, MDU state encoding, RA_REG constant.
- One sub-module: pipe_mdu (FSM, counter, shift registers, HI/LO, sign fix-up).
- ALU and result mux stay in the top module.

Test Plan:
- ealuc=0000, ea=5, eb=0xFFFFFFFF -> ealu=4; ealuc=0100, ea=0, eb=1 -> ealu=0xFFFFFFFF.
- eshift=1, eimm[10:6]=4, ealuc=1111, eb=0x80000000 -> ealu=0xF8000000; ejal=1, epc4=0x100, ern=0 -> ealu=0x104, ern0=31.
- mult ea=0xFFFFFFFE (-2), eb=3 at T -> mdu_stall high T..T+32, low T+33; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Then mflo, followed by a second mflo held 1 cycle -> ealu=0xFFFFFFFA; no second multiply started.
- div ea=-7, eb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu by 0 with ea=9 -> LO=0xFFFFFFFF, HI=9.
- div 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0; stall released at T+33.
- clrn pulse at T+10 of a mult -> mdu_stall=0, HI=LO=0, FSM IDLE; next mult completes correctly.
